// File: rtl/train_sched.sv
// Training-loop sequencer: drives forward/backward/update engines per sample.
// Optional early stop on loss threshold: define TRAIN_SCHED_EARLY_STOP_EN.
module train_sched #(
    parameter int N_SAMPLES  = 4,
    parameter int SAMPLE_W   = 2,
    parameter int MAX_EPOCHS = 200,
    parameter int EPOCH_W    = 8,
    parameter int LOSS_W     = 8,
    parameter int TIMEOUT    = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                start_i,
    input  logic                abort_i,
    output logic                fwd_start_o,
    input  logic                fwd_done_i,
    output logic                bwd_start_o,
    input  logic                bwd_done_i,
    output logic                upd_w_o,
    output logic                clr_grad_o,
    output logic                clr_loss_o,
    output logic [SAMPLE_W-1:0] sample_idx_o,
    output logic [EPOCH_W-1:0]  epoch_o,
    input  logic [LOSS_W-1:0]   loss_i,
    input  logic [LOSS_W-1:0]   loss_thresh_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);

    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT - 1) : 1;
    localparam logic [SAMPLE_W-1:0] LAST_IDX = SAMPLE_W'(N_SAMPLES - 1);
    localparam logic [EPOCH_W-1:0]  EP_MAX   = EPOCH_W'(MAX_EPOCHS);
    localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(TIMEOUT - 2);

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_FWD, S_WAIT_F, S_BWD, S_WAIT_B,
        S_UPD, S_EPOCH, S_NXT, S_DONE, S_ERR
    } state_e;

    state_e              state_q, state_d;
    logic [SAMPLE_W-1:0] idx_q, idx_d;
    logic [EPOCH_W-1:0]  epoch_q, epoch_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic                fwd_q, fwd_d;
    logic                bwd_q, bwd_d;
    logic                upd_q, upd_d;
    logic                clr_loss_q, clr_loss_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                early_stop;

`ifdef TRAIN_SCHED_EARLY_STOP_EN
    assign early_stop = (loss_i < loss_thresh_i);
`else
    logic unused_loss;
    assign unused_loss = ^{loss_i, loss_thresh_i};
    assign early_stop  = 1'b0;
`endif

    // Next state and counters; counter actions land as their state is entered.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        epoch_d = epoch_q;
        tmr_d   = tmr_q;
        if (abort_i) begin
            state_d = S_IDLE;
            idx_d   = '0;
            epoch_d = '0;
            tmr_d   = '0;
        end else if (en_i) begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_d = S_CLR;
                        idx_d   = '0;
                        epoch_d = '0;
                    end
                end
                S_CLR: state_d = S_FWD;
                S_FWD: begin
                    tmr_d   = '0;
                    state_d = S_WAIT_F;
                end
                S_WAIT_F: begin
                    if (fwd_done_i)              state_d = S_BWD;
                    else if (tmr_q == TMR_LAST)  state_d = S_ERR;
                    else                         tmr_d   = tmr_q + 1'b1;
                end
                S_BWD: begin
                    tmr_d   = '0;
                    state_d = S_WAIT_B;
                end
                S_WAIT_B: begin
                    if (bwd_done_i)              state_d = S_UPD;
                    else if (tmr_q == TMR_LAST)  state_d = S_ERR;
                    else                         tmr_d   = tmr_q + 1'b1;
                end
                S_UPD: begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_EPOCH;
                        if (epoch_q != EP_MAX) epoch_d = epoch_q + 1'b1;
                    end else begin
                        state_d = S_FWD;
                        idx_d   = idx_q + 1'b1;
                    end
                end
                S_EPOCH: begin
                    if (epoch_q == EP_MAX || early_stop) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_NXT;
                        idx_d   = '0;
                    end
                end
                S_NXT: state_d = S_FWD;
                S_ERR: state_d = S_ERR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the next state so they come out of flops.
    always_comb begin
        fwd_d      = (state_d == S_FWD);
        bwd_d      = (state_d == S_BWD);
        upd_d      = (state_d == S_UPD);
        clr_loss_d = (state_d == S_CLR) || (state_d == S_NXT);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERR);
        busy_d     = !(state_d == S_IDLE || done_d || err_d);
    end

    // State, counters and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            epoch_q    <= '0;
            tmr_q      <= '0;
            fwd_q      <= 1'b0;
            bwd_q      <= 1'b0;
            upd_q      <= 1'b0;
            clr_loss_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            epoch_q    <= epoch_d;
            tmr_q      <= tmr_d;
            fwd_q      <= fwd_d;
            bwd_q      <= bwd_d;
            upd_q      <= upd_d;
            clr_loss_q <= clr_loss_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // A frozen pulse state must not repeat its pulse while en_i is low.
    assign fwd_start_o  = fwd_q & en_i;
    assign bwd_start_o  = bwd_q & en_i;
    assign upd_w_o      = upd_q & en_i;
    assign clr_grad_o   = upd_q & en_i;
    assign clr_loss_o   = clr_loss_q & en_i;
    assign sample_idx_o = idx_q;
    assign epoch_o      = epoch_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_train_sched.sv
// Directed bench for train_sched: full run, timeout, boundary done,
// enable freeze, abort and restart.
module tb_train_sched;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       en_i;
    logic       start_i;
    logic       abort_i;
    logic       fwd_start_o;
    logic       fwd_done_i;
    logic       bwd_start_o;
    logic       bwd_done_i;
    logic       upd_w_o;
    logic       clr_grad_o;
    logic       clr_loss_o;
    logic [1:0] sample_idx_o;
    logic [7:0] epoch_o;
    logic [7:0] loss_i;
    logic [7:0] loss_thresh_i;
    logic       busy_o;
    logic       done_o;
    logic       err_o;

`ifdef TRAIN_SCHED_EARLY_STOP_EN
    localparam int EXP_EP = 1;
`else
    localparam int EXP_EP = 3;
`endif

    int vectors = 0;
    int miscompares = 0;

    int fwd_lat = 2;
    int bwd_lat = 2;
    int fw = 0;
    int bw = 0;
    logic fd_auto = 1'b0;
    logic bd_auto = 1'b0;
    logic bd_man = 1'b0;
    int cyc = 0;
    int last_f = -1;
    int n_f = 0, n_b = 0, n_u = 0, n_g = 0, n_l = 0;
    int g7 = 0, g9 = 0;

    assign fwd_done_i = fd_auto;
    assign bwd_done_i = bd_auto | bd_man;

    train_sched #(
        .N_SAMPLES(4), .SAMPLE_W(2), .MAX_EPOCHS(3),
        .EPOCH_W(8), .LOSS_W(8), .TIMEOUT(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
        .start_i(start_i), .abort_i(abort_i),
        .fwd_start_o(fwd_start_o), .fwd_done_i(fwd_done_i),
        .bwd_start_o(bwd_start_o), .bwd_done_i(bwd_done_i),
        .upd_w_o(upd_w_o), .clr_grad_o(clr_grad_o),
        .clr_loss_o(clr_loss_o), .sample_idx_o(sample_idx_o),
        .epoch_o(epoch_o), .loss_i(loss_i),
        .loss_thresh_i(loss_thresh_i), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    // Engine model (done lat cycles after start) and pulse monitor.
    always @(negedge clk_i) begin
        cyc++;
        fd_auto = 1'b0;
        bd_auto = 1'b0;
        if (fw > 0) begin
            fw--;
            if (fw == 0) fd_auto = 1'b1;
        end
        if (bw > 0) begin
            bw--;
            if (bw == 0) bd_auto = 1'b1;
        end
        if (fwd_start_o) begin
            n_f++;
            if (last_f >= 0 && cyc - last_f == 7) g7++;
            if (last_f >= 0 && cyc - last_f == 9) g9++;
            last_f = cyc;
            if (fwd_lat > 0) fw = fwd_lat;
        end
        if (bwd_start_o) begin
            n_b++;
            if (bwd_lat > 0) bw = bwd_lat;
        end
        if (upd_w_o)    n_u++;
        if (clr_grad_o) n_g++;
        if (clr_loss_o) n_l++;
    end

    initial begin
        bit seen;
        int pulses;
        rst_i = 1'b0;
        en_i = 1'b1;
        start_i = 1'b0;
        abort_i = 1'b0;
        loss_i = 8'd9;
        loss_thresh_i = 8'd10;
        repeat (2) tick();
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_idx", sample_idx_o, 0);
        check("rst_epoch", epoch_o, 0);
        check("rst_fwd", fwd_start_o, 0);
        rst_i = 1'b1;
        tick();

        // Full training run.
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("run_busy", busy_o, 1);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            tick();
            seen = done_o;
        end
        check("run_done_seen", seen, 1);
        check("run_epoch", epoch_o, EXP_EP);
        check("run_fwd_cnt", n_f, 4 * EXP_EP);
        check("run_bwd_cnt", n_b, 4 * EXP_EP);
        check("run_upd_cnt", n_u, 4 * EXP_EP);
        check("run_grad_cnt", n_g, 4 * EXP_EP);
        check("run_loss_clr", n_l, EXP_EP);
        check("run_gap7", g7, 3 * EXP_EP);
        check("run_gap9", g9, EXP_EP - 1);
        repeat (3) tick();
        check("done_held", done_o, 1);
        check("done_busy", busy_o, 0);

        // Restart from DONE, then abort during epoch 1 sample 2.
        loss_i = 8'd20;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("rs_done_drop", done_o, 0);
        check("rs_clr_loss", clr_loss_o, 1);
        check("rs_epoch0", epoch_o, 0);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            seen = (epoch_o == 8'd1) && (sample_idx_o == 2'd2);
        end
        check("ab_reach", seen, 1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("ab_busy", busy_o, 0);
        check("ab_idx", sample_idx_o, 0);
        check("ab_epoch", epoch_o, 0);
        repeat (3) tick();
        check("ab_idle", busy_o, 0);

        // Forward engine never answers: timeout.
        fwd_lat = 0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("to_clr", clr_loss_o, 1);
        tick();
        check("to_fwd", fwd_start_o, 1);
        repeat (7) tick();
        check("to_err_early", err_o, 0);
        tick();
        check("to_err", err_o, 1);
        check("to_busy", busy_o, 0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (2) tick();
        check("to_err_sticky", err_o, 1);
        check("to_start_ign", busy_o, 0);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("to_abort_err", err_o, 0);
        check("to_abort_busy", busy_o, 0);

        // Done on the last allowed wait cycle, then enable freeze in WAIT_B.
        fwd_lat = 7;
        bwd_lat = 0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        check("lb_fwd", fwd_start_o, 1);
        repeat (8) tick();
        check("lb_bwd", bwd_start_o, 1);
        check("lb_err", err_o, 0);
        repeat (2) tick();
        en_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            pulses = fwd_start_o + bwd_start_o + upd_w_o + clr_grad_o + clr_loss_o;
            check("fz_pulses", pulses, 0);
            check("fz_busy", busy_o, 1);
            check("fz_idx", sample_idx_o, 0);
        end
        en_i = 1'b1;
        repeat (5) tick();
        check("fz_no_err", err_o, 0);
        bd_man = 1'b1;
        tick();
        bd_man = 1'b0;
        check("fz_upd", upd_w_o, 1);
        check("fz_grad", clr_grad_o, 1);
        check("fz_err", err_o, 0);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("end_idle", busy_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
